// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline-stage register with a one-entry skid
// buffer. The main entry drives the outputs; the skid entry catches the beat
// that arrives in the cycle a downstream stall is first seen. Flush turns
// every held entry into a bubble (zero ctrl, out_valid low).
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 9,
    parameter int RD_W   = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic [1:0]        level
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // skid entry
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [RD_W-1:0]   skid_rd;

    // datapath steering decoded from the transition
    logic load_main_in, load_main_skid, load_skid;

    // next values of the registered status outputs
    logic       out_valid_nxt, in_ready_nxt;
    logic [1:0] level_nxt;

    logic acc, take;

    // in_ready and out_valid are flops, so both handshakes are fully registered
    assign acc  = in_valid && in_ready;
    assign take = out_valid && out_ready;

    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= EMPTY;
        else          state <= state_nxt;
    end

    // next-state and datapath-steering decode; flush overrides every transfer
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state_nxt    = BUSY;
                        load_main_in = 1'b1;
                    end
                end
                BUSY: begin
                    if (acc && take) begin
                        load_main_in = 1'b1;
                    end else if (acc) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (take) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    // acc cannot occur here: in_ready is low while FULL
                    if (take) begin
                        state_nxt      = BUSY;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // status outputs as a function of the next state (registered below)
    always_comb begin
        out_valid_nxt = (state_nxt != EMPTY);
        in_ready_nxt  = (state_nxt != FULL);
        level_nxt     = 2'd0;
        case (state_nxt)
            BUSY:    level_nxt = 2'd1;
            FULL:    level_nxt = 2'd2;
            default: level_nxt = 2'd0;
        endcase
    end

    // registered status outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            level     <= 2'd0;
        end else begin
            out_valid <= out_valid_nxt;
            in_ready  <= in_ready_nxt;
            level     <= level_nxt;
        end
    end

    // main entry: loads from input or skid; ctrl zeroed whenever it goes empty
    // so a bubble always carries zero ctrl while data/rd keep their last value
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_ctrl <= '0;
            out_data <= '0;
            out_rd   <= '0;
        end else if (load_main_in) begin
            out_ctrl <= in_ctrl;
            out_data <= in_data;
            out_rd   <= in_rd;
        end else if (load_main_skid) begin
            out_ctrl <= skid_ctrl;
            out_data <= skid_data;
            out_rd   <= skid_rd;
        end else if (state_nxt == EMPTY) begin
            out_ctrl <= '0;
        end
    end

    // skid entry: captures the beat accepted while the head is stalled
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            skid_ctrl <= '0;
            skid_data <= '0;
            skid_rd   <= '0;
        end else if (load_skid) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
            skid_rd   <= in_rd;
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline-stage register. Generalises the fixed EX/MEM latch: data, control and destination-register widths are parameters.
- Adds valid/ready flow control with a one-entry skid buffer, so a downstream stall does not lose an in-flight instruction.
- Flush turns every held entry into a bubble.
- Placed between any two processor stages (ID/EX, EX/MEM, MEM/WB).

Parameters:
DATA_W, 32, width of the data payload (result, operand, branch target, concatenated as needed)
CTRL_W, 9, width of the control-bit vector; forced to 0 on flush or bubble
RD_W, 5, width of the destination-register index

Ports:
clock  input  1  single clock, rising edge
reset_n  input  1  reset, asynchronous, active-low
in_valid  input  1  upstream presents an instruction
in_ready  output  1  stage can accept; transfer when in_valid && in_ready
in_ctrl  input  CTRL_W  upstream control bits
in_data  input  DATA_W  upstream payload
in_rd  input  RD_W  upstream destination register
flush  input  1  discard every held and incoming instruction this cycle
out_valid  output  1  stage holds a valid instruction
out_ready  input  1  downstream accepts; transfer when out_valid && out_ready
out_ctrl  output  CTRL_W  control bits of head entry; 0 when !out_valid
out_data  output  DATA_W  payload of head entry
out_rd  output  RD_W  destination register of head entry
level  output  2  occupancy: 0, 1 or 2 entries

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clock, reset_n).
- Storage: main entry (drives outputs) and skid entry. Each entry holds ctrl, data, rd.
- States: EMPTY (level 0), BUSY (main valid, level 1), FULL (main and skid valid, level 2).
- All outputs are registered. in_ready = !skid_valid, registered.
- Latency: an accepted input appears on out_* the next cycle when the stage is EMPTY, or when it is BUSY and the head is taken the same cycle.
- acc = in_valid && in_ready; take = out_valid && out_ready.
- EMPTY:
  - acc -> BUSY, main <= in.
- BUSY:
  - acc && take -> BUSY, main <= in.
  - acc && !take -> FULL, skid <= in.
  - !acc && take -> EMPTY.
  - otherwise hold.
- FULL (in_ready = 0):
  - take -> BUSY, main <= skid.
  - otherwise hold.
- Stall: with out_ready = 0, out_* hold stable while out_valid = 1. Data must not change under a stall.
- Flush has priority over every transfer. Next state is EMPTY: out_valid = 0, out_ctrl = 0, level = 0, in_ready = 1.
  - An incoming beat in the flush cycle is discarded even if acc.
  - out_data and out_rd keep their last value, because a bubble is defined by zero ctrl.
- Bubble rule: whenever out_valid = 0, out_ctrl = 0.
- Reset (any time, including mid-transfer): state EMPTY, out_valid 0, out_ctrl 0, out_data 0, out_rd 0, level 0, in_ready 1. Skid contents are cleared.
- Reset release follows the normal synchronous update on the next rising edge.
- Width rules: no arithmetic. Fields pass bit-exact, MSB to MSB.
- Simultaneous take + acc in FULL: impossible (in_ready = 0); the input is ignored.

Test Plan:
- Reset, then in_valid = 1, in_ctrl = 9'h1A5, in_data = 32'hDEADBEEF, in_rd = 5'd7, out_ready = 1 -> next cycle out_valid = 1 with those values, level = 1.
- Stream of 8 beats, data 1..8, out_ready held 1 -> outputs 1..8 on consecutive cycles, in_ready stays 1, level never reaches 2.
- Beats A = 32'h11 and B = 32'h22 sent with out_ready = 0 -> level = 2, in_ready = 0, out_data holds 32'h11. Raise out_ready -> 32'h11 then 32'h22, in_ready returns to 1.
- FULL, then flush = 1 with in_valid = 1 -> next cycle out_valid = 0, out_ctrl = 0, level = 0, in_ready = 1, incoming beat never appears.
- reset_n pulsed low between clock edges while BUSY -> outputs go to 0 immediately without a clock edge, level = 0.
